// File: rtl/axi_ram_slave_if.sv
// AXI3-subset channel bundle between the cache-side bridge (master) and the RAM responder (slave).
interface axi_ram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI3-subset RAM responder: one outstanding read and one outstanding write, READ_LATENCY idle cycles before the first R beat.
// Define AXI_RAM_SLAVE_STALL_EN to add LFSR-driven ready/valid stalls for bridge stress testing.
module axi_ram_slave #(
    parameter int          ADDR_WIDTH   = 12,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input logic            clk,
    input logic            reset,
    axi_ram_slave_if.slave axi
);
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_WAIT  = 2'd1;
    localparam logic [1:0] R_BURST = 2'd2;
    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] s, input logic [1:0] b);
        return (b == 2'b01) ? a + (32'd1 << s) : a;
    endfunction

    function automatic logic unsupported(input logic [2:0] s, input logic [1:0] b);
        return b[1] || (s > 3'd2);
    endfunction

    logic [31:0] mem_q [0:(2**ADDR_WIDTH)-1];

    logic addr_stall;
    logic load_stall;

`ifdef AXI_RAM_SLAVE_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign addr_stall = lfsr_q[0];
    assign load_stall = lfsr_q[1];
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign addr_stall  = 1'b0;
    assign load_stall  = 1'b0;
`endif

    // ---------------- read side ----------------
    logic [1:0]  r_state_q, r_state_d;
    logic [3:0]  rid_lat_q, rid_q;
    logic [31:0] raddr_q, rdata_q;
    logic [7:0]  rlen_q, rbeat_q;
    logic [2:0]  rsize_q;
    logic [1:0]  rburst_q, rresp_q;
    logic        rerr_q, rvalid_q, rlast_q;
    logic [3:0]  rwait_q;

    logic        ar_hs, r_hs, wait_done, ld_en, ld_err;
    logic [31:0] ld_addr;
    logic [7:0]  ld_beat, ld_len;
    logic [3:0]  ld_id;

    assign axi.arready = (r_state_q == R_IDLE) && !addr_stall;
    assign ar_hs       = axi.arvalid && axi.arready;
    assign r_hs        = rvalid_q && axi.rready;
    assign wait_done   = ({1'b0, rwait_q} + 5'd1) >= 5'(READ_LATENCY);

    // Selects which beat (if any) is loaded into the R output registers this cycle.
    always_comb begin
        r_state_d = r_state_q;
        ld_en     = 1'b0;
        ld_addr   = raddr_q;
        ld_beat   = rbeat_q;
        ld_len    = rlen_q;
        ld_err    = rerr_q;
        ld_id     = rid_lat_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ld_addr = axi.araddr;
                    ld_beat = 8'd0;
                    ld_len  = axi.arlen;
                    ld_err  = unsupported(axi.arsize, axi.arburst);
                    ld_id   = axi.arid;
                    if (READ_LATENCY == 0 && !load_stall) begin
                        ld_en     = 1'b1;
                        r_state_d = R_BURST;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (wait_done && !load_stall) begin
                    ld_en     = 1'b1;
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        ld_addr = step_addr(raddr_q, rsize_q, rburst_q);
                        ld_beat = rbeat_q + 8'd1;
                        ld_en   = !load_stall;
                    end
                end else if (!rvalid_q && !load_stall) begin
                    ld_en = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 4'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
            rid_lat_q <= 4'd0;
            raddr_q   <= 32'd0;
            rlen_q    <= 8'd0;
            rsize_q   <= 3'd0;
            rburst_q  <= 2'd0;
            rerr_q    <= 1'b0;
            rbeat_q   <= 8'd0;
            rwait_q   <= 4'd0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                rid_lat_q <= axi.arid;
                raddr_q   <= axi.araddr;
                rlen_q    <= axi.arlen;
                rsize_q   <= axi.arsize;
                rburst_q  <= axi.arburst;
                rerr_q    <= unsupported(axi.arsize, axi.arburst);
                rbeat_q   <= 8'd0;
                rwait_q   <= 4'd0;
            end
            if (r_state_q == R_WAIT && !wait_done) rwait_q <= rwait_q + 4'd1;
            if (r_hs && !rlast_q) begin
                raddr_q <= step_addr(raddr_q, rsize_q, rburst_q);
                rbeat_q <= rbeat_q + 8'd1;
            end
            if (r_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
            // A load in the same cycle as a handshake replaces the retiring beat.
            if (ld_en) begin
                rvalid_q <= 1'b1;
                rid_q    <= ld_id;
                rlast_q  <= (ld_beat == ld_len);
                rdata_q  <= ld_err ? 32'd0 : mem_q[ld_addr[ADDR_WIDTH+1:2]];
                rresp_q  <= ld_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign axi.rvalid = rvalid_q;
    assign axi.rlast  = rlast_q;
    assign axi.rid    = rid_q;
    assign axi.rdata  = rdata_q;
    assign axi.rresp  = rresp_q;

    // ---------------- write side ----------------
    logic [1:0]  w_state_q, w_state_d;
    logic [3:0]  wid_lat_q, bid_q;
    logic [31:0] waddr_q;
    logic [7:0]  wlen_q;
    logic [8:0]  wbeat_q;
    logic [2:0]  wsize_q;
    logic [1:0]  wburst_q, bresp_q;
    logic        wunsup_q, wover_q, bvalid_q;
    logic        aw_hs, w_hs, b_hs;

    assign axi.awready = (w_state_q == W_IDLE) && !addr_stall;
    assign axi.wready  = (w_state_q == W_DATA) && !addr_stall;
    assign aw_hs       = axi.awvalid && axi.awready;
    assign w_hs        = axi.wvalid && axi.wready;
    assign b_hs        = bvalid_q && axi.bready;

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && axi.wlast) w_state_d = W_RESP;
            W_RESP:  if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            bvalid_q  <= 1'b0;
            bid_q     <= 4'd0;
            bresp_q   <= RESP_OKAY;
            wid_lat_q <= 4'd0;
            waddr_q   <= 32'd0;
            wlen_q    <= 8'd0;
            wsize_q   <= 3'd0;
            wburst_q  <= 2'd0;
            wunsup_q  <= 1'b0;
            wover_q   <= 1'b0;
            wbeat_q   <= 9'd0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                wid_lat_q <= axi.awid;
                waddr_q   <= axi.awaddr;
                wlen_q    <= axi.awlen;
                wsize_q   <= axi.awsize;
                wburst_q  <= axi.awburst;
                wunsup_q  <= unsupported(axi.awsize, axi.awburst);
                wover_q   <= 1'b0;
                wbeat_q   <= 9'd0;
            end
            if (w_hs) begin
                waddr_q <= step_addr(waddr_q, wsize_q, wburst_q);
                wbeat_q <= wbeat_q + 9'd1;
                if (wbeat_q > {1'b0, wlen_q} && !axi.wlast) wover_q <= 1'b1;
                if (axi.wlast) begin
                    bvalid_q <= 1'b1;
                    bid_q    <= wid_lat_q;
                    bresp_q  <= (wunsup_q || wover_q || wbeat_q != {1'b0, wlen_q}) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            if (b_hs) bvalid_q <= 1'b0;
        end
    end

    // RAM array is deliberately not reset; contents survive a bus reset.
    always_ff @(posedge clk) begin
        if (!reset && w_hs && !wunsup_q) begin
            for (int b = 0; b < 4; b++) begin
                if (axi.wstrb[b]) mem_q[waddr_q[ADDR_WIDTH+1:2]][8*b +: 8] <= axi.wdata[8*b +: 8];
            end
        end
    end

    assign axi.bvalid = bvalid_q;
    assign axi.bid    = bid_q;
    assign axi.bresp  = bresp_q;

    logic unused_ok;
    assign unused_ok = ^{axi.arlock, axi.arcache, axi.arprot, axi.awlock, axi.awcache,
                         axi.awprot, axi.wid, raddr_q, waddr_q};
endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave (default build, READ_LATENCY=2, ADDR_WIDTH=12).
module tb_axi_ram_slave;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    axi_ram_slave_if axi();

    axi_ram_slave #(.ADDR_WIDTH(12), .READ_LATENCY(2), .LFSR_SEED(16'hACE1)) dut (
        .clk   (clk),
        .reset (reset),
        .axi   (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd2; axi.arburst = burst;
        axi.arvalid = 1'b1;
        for (int i = 0; i < 40 && !axi.arready; i++) tick;
        chk("ar_ready", axi.arready, 1);
        tick;
        axi.arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd2; axi.awburst = burst;
        axi.awvalid = 1'b1;
        for (int i = 0; i < 40 && !axi.awready; i++) tick;
        chk("aw_ready", axi.awready, 1);
        tick;
        axi.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
        for (int i = 0; i < 40 && !axi.wready; i++) tick;
        chk("w_ready", axi.wready, 1);
        tick;
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
    endtask

    task automatic b_take(input string tag, input logic [3:0] id, input logic [1:0] resp);
        for (int i = 0; i < 40 && !axi.bvalid; i++) tick;
        chk({tag, "_bvalid"}, axi.bvalid, 1);
        chk({tag, "_bid"}, axi.bid, id);
        chk({tag, "_bresp"}, axi.bresp, resp);
        axi.bready = 1'b1;
        tick;
        axi.bready = 1'b0;
    endtask

    task automatic wait_rvalid(input string tag);
        for (int i = 0; i < 40 && !axi.rvalid; i++) tick;
        chk({tag, "_rvalid"}, axi.rvalid, 1);
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        aw_send(4'd1, addr, 8'd0, 2'b01);
        w_send(data, strb, 1'b1);
        b_take("wr_word", 4'd1, 2'b00);
    endtask

    task automatic read_single(input string tag, input logic [3:0] id, input logic [31:0] addr, input logic [31:0] exp);
        ar_send(id, addr, 8'd0, 2'b01);
        wait_rvalid(tag);
        chk({tag, "_rdata"}, axi.rdata, exp);
        chk({tag, "_rid"}, axi.rid, id);
        chk({tag, "_rlast"}, axi.rlast, 1);
        chk({tag, "_rresp"}, axi.rresp, 2'b00);
        axi.rready = 1'b1;
        tick;
        axi.rready = 1'b0;
    endtask

    logic [3:0] rr_pat;

    initial begin
        axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
        axi.arlock = 0; axi.arcache = 0; axi.arprot = 0; axi.arvalid = 0; axi.rready = 0;
        axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
        axi.awlock = 0; axi.awcache = 0; axi.awprot = 0; axi.awvalid = 0;
        axi.wid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.wvalid = 0; axi.bready = 0;
        reset = 1'b1;
        tick; tick;

        // reset state
        chk("rst_arready", axi.arready, 1);
        chk("rst_awready", axi.awready, 1);
        chk("rst_wready", axi.wready, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_rlast", axi.rlast, 0);
        chk("rst_rdata", axi.rdata, 0);
        chk("rst_rid_bid", {axi.rid, axi.bid, axi.rresp, axi.bresp}, 0);
        reset = 1'b0;
        tick;

        // W before AW is not accepted
        axi.wvalid = 1'b1; axi.wdata = 32'hFFFF_FFFF; axi.wstrb = 4'hF;
        chk("early_w_wready", axi.wready, 0);
        tick;
        chk("early_w_wready2", axi.wready, 0);
        axi.wvalid = 1'b0;

        // single read with exact latency
        write_word(32'h40, 32'hDEADBEEF, 4'hF);
        ar_send(4'd1, 32'h40, 8'd0, 2'b01);
        chk("lat_T1_rvalid", axi.rvalid, 0);
        chk("lat_T1_arready", axi.arready, 0);
        tick;
        chk("lat_T2_rvalid", axi.rvalid, 0);
        tick;
        chk("lat_T3_rvalid", axi.rvalid, 1);
        chk("single_rdata", axi.rdata, 32'hDEADBEEF);
        chk("single_rid", axi.rid, 1);
        chk("single_rlast", axi.rlast, 1);
        chk("single_rresp", axi.rresp, 0);
        axi.rready = 1'b1;
        tick;
        axi.rready = 1'b0;
        chk("single_done_rvalid", axi.rvalid, 0);
        chk("single_done_arready", axi.arready, 1);

        // address wraps modulo the 4096-word array
        read_single("wrap", 4'd9, 32'h4040, 32'hDEADBEEF);

        // line write then back-to-back line read
        aw_send(4'd1, 32'h100, 8'd3, 2'b01);
        w_send(32'h11, 4'hF, 1'b0);
        w_send(32'h22, 4'hF, 1'b0);
        w_send(32'h33, 4'hF, 1'b0);
        w_send(32'h44, 4'hF, 1'b1);
        b_take("line_wr", 4'd1, 2'b00);
        ar_send(4'd2, 32'h100, 8'd3, 2'b01);
        axi.rready = 1'b1;
        wait_rvalid("line_rd");
        chk("line_rid", axi.rid, 2);
        for (int i = 0; i < 4; i++) begin
            chk("line_b2b_rvalid", axi.rvalid, 1);
            chk("line_rdata", axi.rdata, 32'h11 * (i + 1));
            chk("line_rlast", axi.rlast, (i == 3) ? 1 : 0);
            tick;
        end
        chk("line_end_rvalid", axi.rvalid, 0);
        axi.rready = 1'b0;

        // strobe merge
        write_word(32'h200, 32'hAABBCCDD, 4'hF);
        write_word(32'h200, 32'h11223344, 4'b0101);
        read_single("strobe", 4'd3, 32'h200, 32'hAA22CC44);

        // FIXED burst keeps hitting the same word
        aw_send(4'd8, 32'h500, 8'd1, 2'b00);
        w_send(32'h0000_000A, 4'hF, 1'b0);
        w_send(32'h0000_000B, 4'hF, 1'b1);
        b_take("fixed_wr", 4'd8, 2'b00);
        read_single("fixed", 4'd8, 32'h500, 32'h0000_000B);

        // R backpressure: rready 1,0,0,1 then held
        rr_pat = 4'b1001;
        begin
            int beat;
            beat = 0;
            ar_send(4'd3, 32'h100, 8'd3, 2'b01);
            wait_rvalid("bp");
            for (int c = 0; c < 20 && beat < 4; c++) begin
                axi.rready = (c < 4) ? rr_pat[3 - c] : 1'b1;
                chk("bp_rvalid", axi.rvalid, 1);
                chk("bp_rdata", axi.rdata, 32'h11 * (beat + 1));
                chk("bp_rid", axi.rid, 3);
                chk("bp_rlast", axi.rlast, (beat == 3) ? 1 : 0);
                if (axi.rready) beat++;
                tick;
            end
            axi.rready = 1'b0;
            chk("bp_beats", beat, 4);
            chk("bp_end_rvalid", axi.rvalid, 0);
        end

        // B backpressure
        aw_send(4'd5, 32'h300, 8'd0, 2'b01);
        w_send(32'h1234_5678, 4'hF, 1'b1);
        for (int c = 0; c < 5; c++) begin
            chk("bbp_bvalid", axi.bvalid, 1);
            chk("bbp_awready", axi.awready, 0);
            chk("bbp_bid", axi.bid, 5);
            tick;
        end
        axi.bready = 1'b1;
        chk("bbp_bresp", axi.bresp, 0);
        tick;
        axi.bready = 1'b0;
        chk("bbp_done_bvalid", axi.bvalid, 0);
        chk("bbp_done_awready", axi.awready, 1);

        // WRAP read -> SLVERR, zero data, full length
        ar_send(4'd7, 32'h100, 8'd1, 2'b10);
        axi.rready = 1'b1;
        wait_rvalid("err_rd");
        for (int i = 0; i < 2; i++) begin
            chk("err_rvalid", axi.rvalid, 1);
            chk("err_rresp", axi.rresp, 2'b10);
            chk("err_rdata", axi.rdata, 0);
            chk("err_rlast", axi.rlast, (i == 1) ? 1 : 0);
            tick;
        end
        chk("err_end_rvalid", axi.rvalid, 0);
        axi.rready = 1'b0;

        // short write burst -> SLVERR
        aw_send(4'd4, 32'h400, 8'd3, 2'b01);
        w_send(32'h55, 4'hF, 1'b0);
        w_send(32'h66, 4'hF, 1'b1);
        b_take("short_wr", 4'd4, 2'b10);

        // reset in the middle of a read burst
        ar_send(4'd6, 32'h100, 8'd3, 2'b01);
        axi.rready = 1'b1;
        wait_rvalid("mid_rst");
        tick;
        axi.rready = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid_rst_rvalid", axi.rvalid, 0);
        chk("mid_rst_arready", axi.arready, 1);
        tick;
        chk("mid_rst_quiet", axi.rvalid, 0);
        read_single("post_rst", 4'd6, 32'h104, 32'h22);
        read_single("post_rst_ram", 4'd2, 32'h200, 32'hAA22CC44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_ram_slave.md
Name: axi_ram_slave

Overview:
AXI3-subset responder backed by a word-addressed RAM array. It is the other end of the cache-side AXI master bridge: it accepts that bridge's AR/AW/W channels and returns R/B responses. It serves as the simulation and FPGA memory target for the CPU's bridge and for bench-level checks of the bridge. Reads and writes run independently, with one outstanding transaction per direction.

Parameters:
ADDR_WIDTH, 12, word-index bits; the array holds 2^ADDR_WIDTH 32-bit words and is indexed by addr[ADDR_WIDTH+1:2], wrapping modulo the array size.
READ_LATENCY, 2, idle cycles between the AR handshake and the first R beat; legal range 0..15.
LFSR_SEED, 16'hACE1, LFSR seed; used only when the optional feature is compiled in.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
arid  in  4  read ID
araddr  in  32  read byte address
arlen  in  8  beats-1
arsize  in  3  log2 of bytes per beat
arburst  in  2  burst type
arlock/arcache/arprot  in  2/4/3  ignored
arvalid  in  1  / arready out 1  AR handshake
rid  out  4  / rdata out 32 / rresp out 2 / rlast out 1  read beat
rvalid  out  1  / rready in 1  R handshake
awid  in  4 / awaddr in 32 / awlen in 8 / awsize in 3 / awburst in 2  write address
awlock/awcache/awprot  in  2/4/3  ignored
awvalid  in  1  / awready out 1  AW handshake
wid  in  4  ignored
wdata  in  32 / wstrb in 4 / wlast in 1  write beat
wvalid  in  1  / wready out 1  W handshake
bid  out  4  / bresp out 2  write response
bvalid  out  1  / bready in 1  B handshake

Behaviour:
- Interface clocking and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - arready=1, awready=1.
  - wready, rvalid, rlast, bvalid = 0.
  - rid, rdata, rresp, bid, bresp = 0.
  - Both FSMs return to IDLE.
  - RAM contents are not cleared.
  - Reset mid-burst abandons the transaction; no response is produced after reset.

Read FSM (R_IDLE, R_WAIT, R_BURST):
- R_IDLE: arready=1. On arvalid&&arready at cycle T:
  - Latch id, addr, len, size, burst.
  - Set the beat counter to 0 and go to R_WAIT; arready=0 from T+1.
- R_WAIT: count READ_LATENCY cycles. Then load beat 0 so that rvalid=1 first at cycle T+1+READ_LATENCY.
- Beat load:
  - rdata = mem[idx] as of the load cycle. A same-cycle write to that word is not visible.
  - rid = latched id.
  - rlast = (beat == len).
- R_BURST: rvalid and all R outputs hold stable until rvalid&&rready.
  - On a non-last handshake, the next beat is loaded in the following cycle, so back-to-back beats are possible.
  - On the last handshake: rvalid=0, rlast=0, go to R_IDLE, arready=1 next cycle.
- Address step per accepted beat:
  - INCR (2'b01): addr += 1<<size.
  - FIXED (2'b00): no change.
- Error handling: if burst is WRAP or reserved, or size>2, rresp=2'b10 (SLVERR) on every beat and rdata=0. The full len+1 beats are still returned. Otherwise rresp=2'b00.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1, wready=0. On AW handshake: latch id, addr, len, size, burst; go to W_DATA.
- W_DATA: awready=0, wready=1.
  - Each wvalid&&wready writes the bytes of mem[idx] whose wstrb bit is set.
  - Address stepping follows the read rules.
  - The beat counter increments on each beat.
  - W beats presented before the AW handshake are not accepted (wready=0).
- End of burst:
  - On the beat with wlast=1: wready=0, go to W_RESP, bvalid=1 next cycle.
  - bresp=2'b10 if the beat count != len+1, if burst/size is unsupported, or if any beat arrived after len without wlast. Otherwise bresp=2'b00.
  - Unsupported burst/size: no RAM writes occur.
  - Beats beyond len still write, stepping the address.
- W_RESP: bvalid and bid hold stable until bready. Then bvalid=0, go to W_IDLE, awready=1 next cycle.

Concurrency:
- AR and AW may handshake in the same cycle.
- A same-word read load and write in one cycle: the read returns old data, and the write commits.

Optional Feature:
AXI_RAM_SLAVE_STALL_EN:
- When defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seeded with LFSR_SEED on reset) advances every cycle.
  - When LFSR[0]==1: arready and awready are forced 0 in IDLE, and wready is forced 0 in W_DATA.
  - Beat loading (rvalid 0->1) is delayed while LFSR[1]==1.
  - An asserted rvalid or bvalid never drops before its handshake.
- When undefined: no LFSR logic; timing is exactly as specified above.

Test Plan:
- Single read: write 0xDEADBEEF to word 0x10 by backdoor; AR addr=0x40, len=0, size=2, id=1, READ_LATENCY=2, AR handshake at T -> rvalid at T+3, rdata=0xDEADBEEF, rid=1, rlast=1, rresp=0.
- Line write then read: AW addr=0x100, len=3, size=2, INCR; W 0x11,0x22,0x33,0x44 with wlast on beat 4 -> bvalid with bresp=0, bid=1. Then AR len=3 with rready held 1 -> 4 back-to-back beats 0x11..0x44, rlast on beat 4 only.
- Strobe write: word=0xAABBCCDD, write 0x11223344 with wstrb=4'b0101 -> read returns 0xAA22CC44.
- Backpressure: rready toggled 1,0,0,1 during a len=3 burst -> rdata/rid/rlast stable while stalled, 4 beats total. bready held 0 for 5 cycles -> bvalid stays 1 and awready stays 0.
- Errors: AR burst=2'b10, len=1 -> 2 beats with rresp=2'b10, rdata=0. AW len=3 with wlast on beat 2 -> bresp=2'b10.
- Reset mid-burst: assert reset after beat 1 of a len=3 read -> next cycle rvalid=0, arready=1; a new read completes normally and RAM contents are intact.
